// File: rtl/alu_exec_if.sv
// Execute-stage handshake bundle: start/operands in, busy/done/result/flags out.
// No buffering; the producer holds start until busy drops, and results are held until the next done.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic             illegal;

    modport master (
        output start, alu_control, a, b,
        input  busy, done, result, result_hi, zero, overflow, div_by_zero, illegal
    );

    modport slave (
        input  start, alu_control, a, b,
        output busy, done, result, result_hi, zero, overflow, div_by_zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multicycle ALU: MOV/MOVI/ADD/SUB done in 1 cycle, MULT/DIV iterate WIDTH cycles + 1 sign-fix cycle.
// start is only sampled while busy=0; a start during ITER/FIX is dropped, not queued.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_exec_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MOVI = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic             r_neg_q, r_neg_r, r_is_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result, r_result_hi;
    logic             r_zero, r_ovf, r_dbz, r_ill;

    logic             w_launch, w_last, w_go_iter;
    logic [WIDTH-1:0] w_sum, w_dif, w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_sc_res, w_sc_hi;
    logic             w_sc_ovf, w_sc_dbz, w_sc_ill;
    logic [WIDTH:0]   w_madd, w_dsh, w_dsub;
    logic             w_dge;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_q_s, w_r_s, w_fx_res, w_fx_hi;
    logic             w_fx_ovf;

    assign w_launch = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_sum    = bus.a + bus.b;
    assign w_dif    = bus.a - bus.b;
    assign w_a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;

    always_comb begin
        w_sc_res  = '0;
        w_sc_hi   = '0;
        w_sc_ovf  = 1'b0;
        w_sc_dbz  = 1'b0;
        w_sc_ill  = 1'b0;
        w_go_iter = 1'b0;
        case (bus.alu_control)
            OP_MOVI: w_sc_res = bus.b;
            OP_MOV:  w_sc_res = bus.a;
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_dif;
                w_sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MULT: w_go_iter = 1'b1;
            OP_DIV: begin
                if (bus.b == '0) begin
                    w_sc_res = '1;
                    w_sc_hi  = bus.a;
                    w_sc_dbz = 1'b1;
                end else begin
                    w_go_iter = 1'b1;
                end
            end
            default: w_sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_launch ? (w_go_iter ? ITER : DONE) : IDLE;
            ITER:       w_next = w_last ? FIX : ITER;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Shift-add for MULT ({r_hi,r_lo} shifts right); restoring divide for DIV (remainder in r_hi).
    assign w_madd = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};
    assign w_dsh  = {r_hi, r_lo[WIDTH-1]};
    assign w_dge  = (w_dsh >= {1'b0, r_m});
    assign w_dsub = w_dsh - {1'b0, r_m};

    // Only most-negative / -1 yields a positive quotient magnitude with the top bit set.
    assign w_prod_s = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_q_s    = r_neg_q ? -r_lo : r_lo;
    assign w_r_s    = r_neg_r ? -r_hi : r_hi;
    assign w_fx_res = r_is_div ? w_q_s : w_prod_s[WIDTH-1:0];
    assign w_fx_hi  = r_is_div ? w_r_s : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_fx_ovf = r_is_div ? (!r_neg_q && r_lo[WIDTH-1])
                               : (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0; r_lo <= '0; r_m <= '0; r_cnt <= '0;
            r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_div <= 1'b0;
            r_result <= '0; r_result_hi <= '0;
            r_zero <= 1'b0; r_ovf <= 1'b0; r_dbz <= 1'b0; r_ill <= 1'b0;
        end else if (w_launch) begin
            if (w_go_iter) begin
                r_hi     <= '0;
                r_lo     <= w_a_mag;
                r_m      <= w_b_mag;
                r_neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                r_neg_r  <= bus.a[WIDTH-1];
                r_is_div <= (bus.alu_control == OP_DIV);
                r_cnt    <= '0;
            end else begin
                r_result    <= w_sc_res;
                r_result_hi <= w_sc_hi;
                r_zero      <= (w_sc_res == '0);
                r_ovf       <= w_sc_ovf;
                r_dbz       <= w_sc_dbz;
                r_ill       <= w_sc_ill;
            end
        end else if (r_state == ITER) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
                r_hi <= w_dge ? w_dsub[WIDTH-1:0] : w_dsh[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_dge};
            end else begin
                {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
            end
        end else if (r_state == FIX) begin
            r_result    <= w_fx_res;
            r_result_hi <= w_fx_hi;
            r_zero      <= (w_fx_res == '0);
            r_ovf       <= w_fx_ovf;
            r_dbz       <= 1'b0;
            r_ill       <= 1'b0;
        end
    end

    assign bus.busy        = (r_state == ITER) || (r_state == FIX);
    assign bus.done        = (r_state == DONE);
    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.zero        = r_zero;
    assign bus.overflow    = r_ovf;
    assign bus.div_by_zero = r_dbz;
    assign bus.illegal     = r_ill;
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multicycle execution unit that consumes the 4-bit `alu_control` code produced by the ALU control decoder and carries out the selected operation on two register/immediate operands. Single-cycle operations (MOVI, MOV, ADD, SUB) complete in one cycle. MULT and DIV run iteratively over WIDTH cycles. The unit sits in the execute stage and talks to the main control FSM through a start/busy/done handshake.

## Interface
- `WIDTH`, default 32: operand and result width, minimum 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  request an operation; sampled only when `busy`=0.
- `alu_control`  in  4  op code: 0000 MOVI (pass b), 0001 MOV (pass a), 0010 ADD, 0110 SUB, 1000 MULT, 1001 DIV; any other code is illegal.
- `a`  in  WIDTH  operand A, two's complement.
- `b`  in  WIDTH  operand B or immediate, two's complement.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `result`  out  WIDTH  low word, quotient, or ALU result.
- `result_hi`  out  WIDTH  MULT high word or DIV remainder; 0 for the other ops.
- `zero`  out  1  `result`==0.
- `overflow`  out  1  signed overflow; see Operation.
- `div_by_zero`  out  1  DIV issued with b==0.
- `illegal`  out  1  unsupported `alu_control` code.

## Operation
- FSM states: IDLE, ITER, FIX, DONE. Reset enters IDLE.
- Launch: in IDLE or DONE, `start`=1 captures `a`, `b` and `alu_control` into internal registers.
  - Single-cycle ops, illegal codes and DIV with b==0 go to DONE.
  - MULT and DIV with b≠0 go to ITER.
  - In DONE with `start`=0, the FSM returns to IDLE.
- Inputs are not sampled while `busy`=1. `start` during ITER/FIX is ignored and is not queued.
- MOVI: result=b. MOV: result=a. ADD: a+b. SUB: a−b.
  - All wrap modulo 2^WIDTH.
  - `overflow` is the signed overflow of ADD/SUB; it is 0 for MOV and MOVI.
- MULT: signed product of 2·WIDTH bits.
  - Compute on magnitudes with unsigned shift-add, one bit per ITER cycle for WIDTH cycles.
  - FIX negates the product if the signs differed.
  - `{result_hi,result}` = product.
  - `overflow`=1 if `result_hi` is not the sign extension of `result`.
- DIV: signed division, truncating toward zero.
  - Compute on magnitudes with restoring division, one quotient bit per ITER cycle for WIDTH cycles.
  - FIX applies signs: quotient negated if the signs differed; the remainder takes the sign of a.
  - Most-negative ÷ −1 gives result = most-negative, remainder 0, `overflow`=1.
- DIV by zero: result = all ones, `result_hi`=a, `div_by_zero`=1, `overflow`=0.
- Illegal code: result=0, `result_hi`=0, `illegal`=1.
- `zero` is computed from the final `result` of every op, including illegal.
- Output hold:
  - `result`, `result_hi` and all flags update only on the edge that enters DONE.
  - They hold until the next completion.
  - They never show intermediate ITER values.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `result_hi`=0. All flags are 0 except `zero`, which is also registered 0 out of reset.
- Reset mid-operation aborts immediately: FSM returns to IDLE, no `done` pulse, outputs cleared.
- Start is accepted on edge N.
- Single-cycle ops, illegal codes and DIV-by-zero:
  - `done`=1 and outputs valid during cycle N+1.
  - `busy` stays 0.
- MULT and DIV:
  - `busy`=1 from cycle N+1 through N+WIDTH+1 (WIDTH ITER cycles plus 1 FIX cycle).
  - `done`=1 in cycle N+WIDTH+2, with `busy`=0 in that cycle.
- `done` lasts exactly one cycle.
- Back-to-back: `start` held high during the DONE cycle launches the next op; `done` can therefore be high on consecutive cycles for single-cycle ops.

## Test plan
- Signed overflow: WIDTH=32, ADD a=0x7FFFFFFF, b=1 → cycle N+1: `done`=1, result=0x80000000, `overflow`=1, `busy` never high.
- Signed MULT: MULT a=−3, b=5 → `busy` high for 33 cycles, then `done` in N+34 with result=0xFFFFFFF1, `result_hi`=0xFFFFFFFF, `overflow`=0. Changing a/b mid-op must not alter the result.
- DIV sign and overflow rules:
  - DIV a=−7, b=2 → result=0xFFFFFFFD, `result_hi`=0xFFFFFFFF.
  - DIV a=0x80000000, b=−1 → result=0x80000000, `result_hi`=0, `overflow`=1.
- DIV by zero: DIV a=42, b=0 → `done` in N+1, result=0xFFFFFFFF, `result_hi`=42, `div_by_zero`=1.
- Reset mid-op: assert `reset` 10 cycles into a MULT → `busy`, `done`, result and flags all 0 at once, and no `done` follows. Then SUB a=5, b=5 → result=0, `zero`=1 in N+1.
- Busy and illegal handling:
  - `start` pulsed during DIV ITER is ignored and only one `done` is seen.
  - `alu_control`=0101 → `done` in N+1, `illegal`=1, result=0, `zero`=1.
